// File: rtl/path_trace_reader.sv
// path_trace_reader
//   Walks the predecessor records produced by a shortest-path engine
//   from a destination vertex back to a source vertex. Each vertex is
//   pushed onto a stack, then the stack is drained so that the path
//   comes out in source-to-destination order over a ready/valid
//   stream.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : one-cycle trace request, sampled only while idle
//   source_num   : source vertex id
//   destination  : destination vertex id
//   vertice_num  : vertex count, bounds the number of trace steps
//   mem_rd_en    : result-memory read strobe
//   mem_addr     : result-memory address {5'b0, vertex}
//   mem_rdata    : result record, valid the cycle after mem_rd_en
//                  ([7:0] predecessor, [80] unreachable flag)
//   out_vertex   : path vertex
//   out_valid    : out_vertex valid
//   out_ready    : consumer accepts out_vertex
//   out_last     : final (destination) vertex marker
//   busy         : high whenever a trace is in progress
//   done         : one-cycle pulse at the end of every trace
//   error        : 00 ok, 01 unreachable, 10 loop / stack overflow
module path_trace_reader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   source_num,
  input  logic [7:0]   destination,
  input  logic [7:0]   vertice_num,
  output logic         mem_rd_en,
  output logic [12:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [7:0]   out_vertex,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [1:0]   error
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    POP,
    DONE
  } state_t;

  state_t            state_q;
  logic [SP_W-1:0]   sp_q;
  logic [7:0]        cur_q;
  logic [7:0]        step_q;
  logic [7:0]        src_q;
  logic [7:0]        vn_q;

  logic              mem_rd_en_q;
  logic [12:0]       mem_addr_q;
  logic [7:0]        out_vertex_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        error_q;

  logic [7:0]        stack_q [DEPTH];

  logic              wr_en_d;
  logic [IDX_W-1:0]  wr_idx_d;
  logic [7:0]        wr_data_d;

  logic [7:0]        pred;
  logic              unreachable;
  logic [7:0]        step_inc;
  logic              stack_full;
  logic              step_limit;
  logic [IDX_W-1:0]  next_top_idx;
  logic              unused_rdata;

  assign pred         = mem_rdata[7:0];
  assign unreachable  = mem_rdata[80];
  assign step_inc     = step_q + 8'd1;
  assign stack_full   = (sp_q == SP_W'(DEPTH));
  // The step limit counts the read just returned: a vertex count of N
  // permits at most N-1 successful steps, the N-th read is flagged.
  assign step_limit   = (step_inc == vn_q);
  // Entry below the current top, presented after a non-final pop.
  assign next_top_idx = IDX_W'(sp_q - SP_W'(2));
  assign unused_rdata = ^{mem_rdata[127:81], mem_rdata[79:8]};

  // Stack write port: destination on accept, predecessor on a good step.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = '0;
          wr_data_d = destination;
        end
      end
      CHECK: begin
        if (!unreachable && !stack_full && !step_limit) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = IDX_W'(sp_q);
          wr_data_d = pred;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en_d) begin
      stack_q[wr_idx_d] <= wr_data_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sp_q         <= '0;
      cur_q        <= '0;
      step_q       <= '0;
      src_q        <= '0;
      vn_q         <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      out_vertex_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= source_num;
            vn_q    <= vertice_num;
            sp_q    <= SP_W'(1);
            step_q  <= '0;
            error_q <= 2'b00;
            busy_q  <= 1'b1;
            if (destination == source_num) begin
              out_valid_q  <= 1'b1;
              out_vertex_q <= destination;
              out_last_q   <= 1'b1;
              state_q      <= POP;
            end else begin
              cur_q       <= destination;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= {5'b00000, destination};
              state_q     <= ISSUE;
            end
          end
        end

        ISSUE: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= CHECK;
        end

        CHECK: begin
          if (unreachable) begin
            error_q <= 2'b01;
            sp_q    <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (stack_full || step_limit) begin
            error_q <= 2'b10;
            sp_q    <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            sp_q   <= sp_q + SP_W'(1);
            step_q <= step_inc;
            if (pred == src_q) begin
              // The predecessor is the new top; present it directly
              // since the stack write lands on this same edge.
              out_valid_q  <= 1'b1;
              out_vertex_q <= pred;
              out_last_q   <= 1'b0;
              state_q      <= POP;
            end else begin
              cur_q       <= pred;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= {5'b00000, pred};
              state_q     <= ISSUE;
            end
          end
        end

        POP: begin
          if (out_valid_q && out_ready) begin
            sp_q <= sp_q - SP_W'(1);
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              out_vertex_q <= stack_q[next_top_idx];
              out_last_q   <= (sp_q == SP_W'(2));
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign out_vertex = out_vertex_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_path_trace_reader.sv
// Directed bench for path_trace_reader with a registered result-memory
// model and stream monitors that log reads and handshakes.
module tb_path_trace_reader;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   source_num = '0;
  logic [7:0]   destination = '0;
  logic [7:0]   vertice_num = '0;
  logic         mem_rd_en;
  logic [12:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [7:0]   out_vertex;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [1:0]   error;

  always #5 clock = ~clock;

  path_trace_reader #(.DEPTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .source_num  (source_num),
    .destination (destination),
    .vertice_num (vertice_num),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_vertex  (out_vertex),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  logic [127:0] rec [0:255];
  int tests = 0;
  int fails = 0;

  logic [12:0] rd_q [$];
  logic [7:0]  hs_v [$];
  logic        hs_l [$];
  int done_cnt  = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;
  int stall_err = 0;
  logic       stalled = 1'b0;
  logic [7:0] stalled_v = '0;

  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_rdata <= rec[mem_addr[7:0]];
      rd_q.push_back(mem_addr);
    end
    if (out_valid) valid_cnt++;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      hs_v.push_back(out_vertex);
      hs_l.push_back(out_last);
    end
    if (stalled && out_valid && (out_vertex !== stalled_v)) stall_err++;
    if (out_valid && !out_ready) stall_cnt++;
    stalled   <= out_valid && !out_ready;
    stalled_v <= out_vertex;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) rec[i] = '0;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    @(negedge clock);
    source_num  = s;
    destination = d;
    vertice_num = n;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      if (toggle) out_ready = ~out_ready;
    end
  endtask

  task automatic test_reset();
    int r0;
    int v0;
    repeat (2) @(negedge clock);
    tests++;
    if ({mem_rd_en, mem_addr, out_vertex, out_valid, out_last} !== '0) begin
      fails++;
      $display("FAIL reset_datapath got rd=%b addr=%h v=%h valid=%b last=%b exp all 0",
               mem_rd_en, mem_addr, out_vertex, out_valid, out_last);
    end
    tests++;
    if ({busy, done, error} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_status got busy=%b done=%b error=%b exp 0 0 00", busy, done, error);
    end
    r0 = rd_q.size();
    v0 = valid_cnt;
    reset = 1'b1;
    repeat (6) @(negedge clock);
    tests++;
    if ((rd_q.size() - r0) != 0 || (valid_cnt - v0) != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got reads=%0d valid=%0d busy=%b exp 0 0 0",
               rd_q.size() - r0, valid_cnt - v0, busy);
    end
  endtask

  task automatic test_basic_path();
    int r0, h0, d0;
    bit ok;
    logic [1:0]  err;
    logic [25:0] got_rd;
    logic [23:0] got_v;
    logic [2:0]  got_l;
    clear_mem();
    rec[5] = 128'd3;
    rec[3] = 128'd1;
    out_ready = 1'b1;
    r0 = rd_q.size(); h0 = hs_v.size(); d0 = done_cnt;
    pulse_start(8'd1, 8'd5, 8'd8);
    wait_done(100, 1'b0, ok);
    err = error;
    repeat (2) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout got no done exp done within 100 cycles"); end
    got_rd = 'x;
    if (rd_q.size() == r0 + 2) got_rd = {rd_q[r0], rd_q[r0+1]};
    tests++;
    if (got_rd !== {13'd5, 13'd3}) begin
      fails++;
      $display("FAIL basic_reads got n=%0d addrs=%h exp n=2 addrs 5,3", rd_q.size() - r0, got_rd);
    end
    got_v = 'x; got_l = 'x;
    if (hs_v.size() == h0 + 3) begin
      got_v = {hs_v[h0], hs_v[h0+1], hs_v[h0+2]};
      got_l = {hs_l[h0], hs_l[h0+1], hs_l[h0+2]};
    end
    tests++;
    if (got_v !== 24'h010305) begin
      fails++;
      $display("FAIL basic_path got n=%0d path=%h exp 010305", hs_v.size() - h0, got_v);
    end
    tests++;
    if (got_l !== 3'b001) begin fails++; $display("FAIL basic_last got %b exp 001", got_l); end
    tests++;
    if (err !== 2'b00 || (done_cnt - d0) != 1) begin
      fails++;
      $display("FAIL basic_done got error=%b pulses=%0d exp 00 1", err, done_cnt - d0);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_same_vertex();
    int r0, h0, d0, v0;
    bit ok;
    logic [1:0] err;
    clear_mem();
    out_ready = 1'b1;
    r0 = rd_q.size(); h0 = hs_v.size(); d0 = done_cnt;
    pulse_start(8'd2, 8'd2, 8'd8);
    wait_done(50, 1'b0, ok);
    err = error;
    // Start raised during the DONE cycle must be ignored.
    start = 1'b1; source_num = 8'd1; destination = 8'd7;
    @(negedge clock);
    start = 1'b0;
    v0 = valid_cnt;
    repeat (5) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL same_timeout got no done exp done within 50 cycles"); end
    tests++;
    if ((rd_q.size() - r0) != 0) begin
      fails++; $display("FAIL same_reads got %0d exp 0", rd_q.size() - r0);
    end
    tests++;
    if (hs_v.size() != h0 + 1 || hs_v[h0] !== 8'd2 || hs_l[h0] !== 1'b1) begin
      fails++;
      $display("FAIL same_path got n=%0d first=%h last=%b exp n=1 02 1", hs_v.size() - h0,
               (hs_v.size() > h0) ? hs_v[h0] : 8'hxx, (hs_l.size() > h0) ? hs_l[h0] : 1'bx);
    end
    tests++;
    if (err !== 2'b00 || (done_cnt - d0) != 1) begin
      fails++; $display("FAIL same_done got error=%b pulses=%0d exp 00 1", err, done_cnt - d0);
    end
    tests++;
    if ((valid_cnt - v0) != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_in_done got valid=%0d busy=%b exp 0 0", valid_cnt - v0, busy);
    end
  endtask

  task automatic test_unreachable();
    int r0, v0, d0;
    bit ok;
    logic [1:0] err;
    clear_mem();
    rec[4] = 128'h00000000000100000000000000000000;
    out_ready = 1'b1;
    r0 = rd_q.size(); v0 = valid_cnt; d0 = done_cnt;
    pulse_start(8'd1, 8'd4, 8'd8);
    wait_done(50, 1'b0, ok);
    err = error;
    repeat (2) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL unreach_timeout got no done exp done within 50 cycles"); end
    tests++;
    if (rd_q.size() != r0 + 1 || rd_q[r0] !== 13'd4) begin
      fails++; $display("FAIL unreach_reads got n=%0d exp one read of addr 4", rd_q.size() - r0);
    end
    tests++;
    if ((valid_cnt - v0) != 0) begin
      fails++; $display("FAIL unreach_valid got %0d exp 0", valid_cnt - v0);
    end
    tests++;
    if (err !== 2'b01 || (done_cnt - d0) != 1) begin
      fails++; $display("FAIL unreach_error got error=%b pulses=%0d exp 01 1", err, done_cnt - d0);
    end
  endtask

  task automatic test_loop();
    int r0, v0;
    bit ok;
    logic [1:0]  err;
    logic [51:0] got_rd;
    clear_mem();
    rec[6] = 128'd7;
    rec[7] = 128'd6;
    out_ready = 1'b1;
    r0 = rd_q.size(); v0 = valid_cnt;
    pulse_start(8'd1, 8'd6, 8'd4);
    wait_done(100, 1'b0, ok);
    err = error;
    repeat (6) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL loop_timeout got no done exp done within 100 cycles"); end
    got_rd = 'x;
    if (rd_q.size() == r0 + 4) got_rd = {rd_q[r0], rd_q[r0+1], rd_q[r0+2], rd_q[r0+3]};
    tests++;
    if (got_rd !== {13'd6, 13'd7, 13'd6, 13'd7}) begin
      fails++;
      $display("FAIL loop_reads got n=%0d addrs=%h exp n=4 addrs 6,7,6,7", rd_q.size() - r0, got_rd);
    end
    tests++;
    if ((valid_cnt - v0) != 0) begin
      fails++; $display("FAIL loop_valid got %0d exp 0", valid_cnt - v0);
    end
    tests++;
    if (err !== 2'b10) begin fails++; $display("FAIL loop_error got %b exp 10", err); end
    tests++;
    if (error !== 2'b10) begin fails++; $display("FAIL loop_error_held got %b exp 10", error); end
  endtask

  task automatic test_overflow();
    int r0;
    bit ok;
    logic [1:0] err;
    clear_mem();
    rec[6] = 128'd7;
    rec[7] = 128'd6;
    out_ready = 1'b1;
    r0 = rd_q.size();
    // vertex count 0 never matches the step counter early, so the
    // 32-entry stack is what stops the walk.
    pulse_start(8'd1, 8'd6, 8'd0);
    wait_done(300, 1'b0, ok);
    err = error;
    repeat (2) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL ovf_timeout got no done exp done within 300 cycles"); end
    tests++;
    if ((rd_q.size() - r0) != 32) begin
      fails++; $display("FAIL ovf_reads got %0d exp 32", rd_q.size() - r0);
    end
    tests++;
    if (err !== 2'b10) begin fails++; $display("FAIL ovf_error got %b exp 10", err); end
  endtask

  task automatic test_backpressure();
    int h0, s0, e0;
    bit ok;
    logic [23:0] got_v;
    clear_mem();
    rec[5] = 128'd3;
    rec[3] = 128'd1;
    out_ready = 1'b0;
    h0 = hs_v.size(); s0 = stall_cnt; e0 = stall_err;
    pulse_start(8'd1, 8'd5, 8'd8);
    wait_done(100, 1'b1, ok);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_timeout got no done exp done within 100 cycles"); end
    got_v = 'x;
    if (hs_v.size() == h0 + 3) got_v = {hs_v[h0], hs_v[h0+1], hs_v[h0+2]};
    tests++;
    if (got_v !== 24'h010305) begin
      fails++; $display("FAIL bp_path got n=%0d path=%h exp 3 handshakes 010305", hs_v.size() - h0, got_v);
    end
    tests++;
    if ((stall_err - e0) != 0) begin
      fails++; $display("FAIL bp_stable got %0d changes while stalled exp 0", stall_err - e0);
    end
    tests++;
    if ((stall_cnt - s0) == 0) begin
      fails++; $display("FAIL bp_stalls got 0 stalled cycles exp at least 1");
    end
  endtask

  task automatic test_start_ignored();
    int r0, h0, d0;
    bit ok;
    int i;
    logic [23:0] got_v;
    clear_mem();
    rec[5] = 128'd3;
    rec[3] = 128'd1;
    out_ready = 1'b0;
    r0 = rd_q.size(); h0 = hs_v.size(); d0 = done_cnt;
    pulse_start(8'd1, 8'd5, 8'd8);
    for (i = 0; i < 50 && out_valid !== 1'b1; i++) @(negedge clock);
    pulse_start(8'd2, 8'd2, 8'd8);
    tests++;
    if (out_vertex !== 8'd1 || out_valid !== 1'b1) begin
      fails++; $display("FAIL ign_hold got v=%h valid=%b exp 01 1", out_vertex, out_valid);
    end
    out_ready = 1'b1;
    wait_done(100, 1'b0, ok);
    repeat (6) @(negedge clock);
    got_v = 'x;
    if (hs_v.size() == h0 + 3) got_v = {hs_v[h0], hs_v[h0+1], hs_v[h0+2]};
    tests++;
    if (!ok || got_v !== 24'h010305) begin
      fails++; $display("FAIL ign_path got done=%b path=%h exp 1 010305", ok, got_v);
    end
    tests++;
    if ((done_cnt - d0) != 1 || (rd_q.size() - r0) != 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_extra got pulses=%0d reads=%0d busy=%b exp 1 2 0",
               done_cnt - d0, rd_q.size() - r0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int h0;
    bit ok;
    int i;
    logic [23:0] got_v;
    clear_mem();
    rec[5] = 128'd3;
    rec[3] = 128'd1;
    out_ready = 1'b0;
    pulse_start(8'd1, 8'd5, 8'd8);
    for (i = 0; i < 50 && out_valid !== 1'b1; i++) @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_vertex !== 8'd3) begin
      fails++; $display("FAIL mid_second got v=%h valid=%b exp 03 1", out_vertex, out_valid);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if ({mem_rd_en, mem_addr, out_vertex, out_valid, out_last, busy, done, error} !== '0) begin
      fails++;
      $display("FAIL mid_reset got rd=%b addr=%h v=%h valid=%b last=%b busy=%b done=%b err=%b exp all 0",
               mem_rd_en, mem_addr, out_vertex, out_valid, out_last, busy, done, error);
    end
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    h0 = hs_v.size();
    pulse_start(8'd1, 8'd5, 8'd8);
    wait_done(100, 1'b0, ok);
    repeat (2) @(negedge clock);
    got_v = 'x;
    if (hs_v.size() == h0 + 3) got_v = {hs_v[h0], hs_v[h0+1], hs_v[h0+2]};
    tests++;
    if (!ok || got_v !== 24'h010305 || error !== 2'b00) begin
      fails++;
      $display("FAIL mid_retrace got done=%b path=%h err=%b exp 1 010305 00", ok, got_v, error);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic_path();
    test_same_vertex();
    test_unreachable();
    test_loop();
    test_overflow();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
